// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU sequencer: FSM states and instruction field positions.
package hack_pkg;

  localparam int ADDR_W_DEF = 15;

  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MREAD,
    ST_EXEC,
    ST_MWRITE,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Instruction ROM and data RAM req/ack bus between the sequencer (master) and memories (slave).
interface hack_cpu_ctrl_if #(
  parameter int ADDR_W = 15
) ();

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [15:0]       rom_data;

  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              ram_ack;

  modport master (
    output rom_req, rom_addr,
    input  rom_ack, rom_data,
    output ram_rd, ram_wr, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  rom_req, rom_addr,
    output rom_ack, rom_data,
    input  ram_rd, ram_wr, ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );

endinterface

// File: rtl/hack_jump_cond.sv
// Hack jump decision from the jjj bits and the ALU zero/negative flags.
module hack_jump_cond (
  input  logic [2:0] jjj,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (jjj[2] & ng) | (jjj[1] & zr) | (jjj[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU sequencer around an external combinational ALU.
// Owns A, D, PC and IR; talks to ROM and RAM through req/ack handshakes with arbitrary wait states.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  hack_cpu_ctrl_if.master   mem,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_ctl,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [15:0]       a_dbg,
  output logic [15:0]       d_dbg,
  output logic              retire
);

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [15:0]       a_reg;
  logic [15:0]       d_reg;
  logic [15:0]       ir_reg;
  logic [15:0]       m_reg;
  logic [15:0]       r_reg;
  logic              zr_reg;
  logic              ng_reg;
  logic              rom_req_reg;
  logic              take;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_reg + 1'b1;

  hack_jump_cond u_jump (
    .jjj  (ir_reg[JMP_HI:JMP_LO]),
    .zr   (zr_reg),
    .ng   (ng_reg),
    .take (take)
  );

  assign mem.rom_req   = rom_req_reg;
  assign mem.rom_addr  = pc_reg;
  assign mem.ram_rd    = (state_reg == ST_MREAD);
  assign mem.ram_wr    = (state_reg == ST_MWRITE);
  assign mem.ram_addr  = a_reg[ADDR_W-1:0];
  assign mem.ram_wdata = r_reg;

  assign alu_x   = d_reg;
  assign alu_y   = ir_reg[A_BIT] ? m_reg : a_reg;
  assign alu_ctl = ir_reg[COMP_HI:COMP_LO];

  assign retire = ((state_reg == ST_DECODE) && !ir_reg[IS_C]) || (state_reg == ST_COMMIT);

  assign pc_dbg = pc_reg;
  assign a_dbg  = a_reg;
  assign d_dbg  = d_reg;

  // The next fetch request is raised on the retire edge when run is high,
  // which is what gives the 2-cycle A-instruction and 4-cycle C-instruction cadence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= RESET_PC;
      a_reg       <= '0;
      d_reg       <= '0;
      ir_reg      <= '0;
      m_reg       <= '0;
      r_reg       <= '0;
      zr_reg      <= 1'b0;
      ng_reg      <= 1'b0;
      rom_req_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (rom_req_reg) begin
            if (mem.rom_ack) begin
              ir_reg      <= mem.rom_data;
              rom_req_reg <= 1'b0;
              state_reg   <= ST_DECODE;
            end
          end else if (run) begin
            rom_req_reg <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!ir_reg[IS_C]) begin
            a_reg       <= {1'b0, ir_reg[14:0]};
            pc_reg      <= pc_inc;
            rom_req_reg <= run;
            state_reg   <= ST_FETCH;
          end else begin
            state_reg <= ir_reg[A_BIT] ? ST_MREAD : ST_EXEC;
          end
        end
        ST_MREAD: begin
          if (mem.ram_ack) begin
            m_reg     <= mem.ram_rdata;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_reg     <= alu_out;
          zr_reg    <= alu_zr;
          ng_reg    <= alu_ng;
          state_reg <= ir_reg[DEST_M] ? ST_MWRITE : ST_COMMIT;
        end
        ST_MWRITE: begin
          if (mem.ram_ack) state_reg <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // a_reg on the right-hand side is still the pre-instruction A.
          if (ir_reg[DEST_D]) d_reg <= r_reg;
          if (ir_reg[DEST_A]) a_reg <= r_reg;
          pc_reg      <= take ? a_reg[ADDR_W-1:0] : pc_inc;
          rom_req_reg <= run;
          state_reg   <= ST_FETCH;
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard bench: an ISA-level Hack interpreter predicts every retirement and RAM write.
module tb_hack_cpu_ctrl;
  import hack_pkg::*;

  localparam int AW    = 15;
  localparam int MEMSZ = 1 << AW;

  typedef struct {
    logic [AW-1:0] pc;
    logic [15:0]   a;
    logic [15:0]   d;
    int            cycles;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  hack_cpu_ctrl_if #(.ADDR_W(AW)) mem ();

  logic [15:0]   alu_x, alu_y, alu_out, a_dbg, d_dbg;
  logic [5:0]    alu_ctl;
  logic          alu_zr, alu_ng, retire;
  logic [AW-1:0] pc_dbg;

  hack_cpu_ctrl #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .mem     (mem),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_ctl (alu_ctl),
    .alu_out (alu_out),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng),
    .pc_dbg  (pc_dbg),
    .a_dbg   (a_dbg),
    .d_dbg   (d_dbg),
    .retire  (retire)
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? xx + yy : xx & yy;
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, alu_ctl);
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[15];

  // Memories with random wait states
  logic [15:0] rom  [MEMSZ];
  logic [15:0] ram  [MEMSZ];
  logic [15:0] mram [MEMSZ];
  int rom_cnt, rom_wait, ram_cnt, ram_wait;
  int rom_wait_min = 0, rom_wait_max = 0, ram_wait_max = 0;

  assign mem.rom_ack   = mem.rom_req && (rom_cnt >= rom_wait);
  assign mem.rom_data  = rom[mem.rom_addr];
  assign mem.ram_ack   = (mem.ram_rd || mem.ram_wr) && (ram_cnt >= ram_wait);
  assign mem.ram_rdata = ram[mem.ram_addr];

  always @(posedge clk) begin
    if (mem.rom_req && !mem.rom_ack) rom_cnt <= rom_cnt + 1;
    else begin
      rom_cnt  <= 0;
      rom_wait <= $urandom_range(rom_wait_max, rom_wait_min);
    end
    if ((mem.ram_rd || mem.ram_wr) && !mem.ram_ack) ram_cnt <= ram_cnt + 1;
    else begin
      ram_cnt  <= 0;
      ram_wait <= $urandom_range(ram_wait_max, 0);
    end
  end

  // Scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  bit   check_cycles = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: one Hack instruction per step, straight from the ISA
  logic [AW-1:0] m_pc;
  logic [15:0]   m_a, m_d;

  task automatic run_model(input int n);
    logic [15:0] ir, y, o;
    logic        jmp;
    logic [AW-1:0] npc;
    int cyc;
    for (int i = 0; i < n; i++) begin
      ir = rom[m_pc];
      if (!ir[15]) begin
        m_a  = {1'b0, ir[14:0]};
        m_pc = m_pc + 1'b1;
        cyc  = 2;
      end else begin
        y   = ir[12] ? mram[m_a[AW-1:0]] : m_a;
        o   = hack_alu(m_d, y, ir[11:6]);
        cyc = 4 + int'(ir[12]) + int'(ir[3]);
        if (ir[3]) begin
          mram[m_a[AW-1:0]] = o;
          wr_q.push_back('{addr: m_a[AW-1:0], data: o});
        end
        jmp = (ir[2] && $signed(o) < 0) || (ir[1] && o == 16'h0) || (ir[0] && $signed(o) > 0);
        npc = jmp ? m_a[AW-1:0] : m_pc + 1'b1;
        if (ir[5]) m_a = o;
        if (ir[4]) m_d = o;
        m_pc = npc;
      end
      exp_q.push_back('{pc: m_pc, a: m_a, d: m_d, cycles: cyc});
    end
  endtask

  // Monitor
  int cyc_cnt = 0, start_cyc = 0, n_ret = 0, len;
  bit in_instr = 0, prev_rom_pend = 0, prev_ram_pend = 0;
  logic [AW-1:0] prev_rom_addr, prev_ram_addr;
  logic [1:0]    prev_ram_kind;
  logic [15:0]   prev_wdata;
  exp_t e;
  wr_t  w;

  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (!reset_n) begin
        in_instr = 0; prev_rom_pend = 0; prev_ram_pend = 0;
        continue;
      end
      chk($countones({mem.rom_req, mem.ram_rd, mem.ram_wr}) <= 1, "one_req",
          {29'b0, mem.rom_req, mem.ram_rd, mem.ram_wr}, 32'h0);
      if (prev_rom_pend)
        chk(mem.rom_req && mem.rom_addr == prev_rom_addr, "rom_hold",
            {mem.rom_req, mem.rom_addr}, {1'b1, prev_rom_addr});
      if (prev_ram_pend)
        chk({mem.ram_rd, mem.ram_wr} == prev_ram_kind && mem.ram_addr == prev_ram_addr &&
            (!mem.ram_wr || mem.ram_wdata == prev_wdata), "ram_hold",
            {mem.ram_rd, mem.ram_wr, mem.ram_addr}, {prev_ram_kind, prev_ram_addr});
      prev_rom_pend = mem.rom_req && !mem.rom_ack;
      prev_rom_addr = mem.rom_addr;
      prev_ram_pend = (mem.ram_rd || mem.ram_wr) && !mem.ram_ack;
      prev_ram_kind = {mem.ram_rd, mem.ram_wr};
      prev_ram_addr = mem.ram_addr;
      prev_wdata    = mem.ram_wdata;
      if (mem.ram_wr && mem.ram_ack) begin
        ram[mem.ram_addr] = mem.ram_wdata;
        if (wr_q.size() == 0) chk(1'b0, "wr_unexpected", {17'b0, mem.ram_addr}, 32'h0);
        else begin
          w = wr_q.pop_front();
          chk(mem.ram_addr == w.addr, "wr_addr", mem.ram_addr, w.addr);
          chk(mem.ram_wdata == w.data, "wr_data", mem.ram_wdata, w.data);
        end
      end
      if (mem.rom_req && !in_instr) begin
        in_instr  = 1;
        start_cyc = cyc_cnt;
      end
      if (retire) begin
        len = cyc_cnt - start_cyc + 1;
        in_instr = 0;
        if (exp_q.size() == 0) chk(1'b0, "retire_unexpected", pc_dbg, 32'h0);
        else begin
          e = exp_q.pop_front();
          if (check_cycles) chk(len == e.cycles, "cycles", len, e.cycles);
          @(posedge clk);
          #1;
          n_ret++;
          $display("retire %0d: pc=%h a=%h d=%h cycles=%0d", n_ret, pc_dbg, a_dbg, d_dbg, len);
          chk(pc_dbg == e.pc, "pc", pc_dbg, e.pc);
          chk(a_dbg == e.a, "a", a_dbg, e.a);
          chk(d_dbg == e.d, "d", d_dbg, e.d);
        end
      end
    end
  end

  // Stimulus helpers
  task automatic load_directed();
    logic [15:0] prog [13];
    prog = '{16'h0007, 16'hEC10, 16'h0005, 16'hEC10, 16'h0064, 16'hF088, 16'h0028,
             16'hEE90, 16'hE301, 16'h0003, 16'hEC10, 16'h0028, 16'hE301};
    for (int i = 0; i < 13; i++) rom[i] = prog[i];
    rom[40] = 16'h0014;  rom[41] = 16'hFCAF;
    rom[20] = 16'h7FFF;  rom[21] = 16'hEA87;
    rom[MEMSZ-1] = 16'h0055;
  endtask

  task automatic model_reset();
    m_pc = '0; m_a = '0; m_d = '0;
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic run_prog(input int n);
    int cnt = 0;
    run = 1'b1;
    for (int c = 0; c < n * 60 && cnt < n; c++) begin
      @(negedge clk);
      if (retire) begin
        cnt++;
        if (cnt == n) run = 1'b0;
      end
    end
    run = 1'b0;
    chk(cnt == n, "retire_count", cnt, n);
    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "exp_drained", exp_q.size(), 0);
    chk(wr_q.size() == 0, "wr_drained", wr_q.size(), 0);
  endtask

  task automatic idle_check();
    bit seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem.rom_req) seen = 1;
    end
    chk(!seen, "idle_no_req", seen, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < MEMSZ; i++) begin
      rom[i]  = 16'($urandom);
      ram[i]  = 16'($urandom);
      mram[i] = ram[i];
    end
    model_reset();
    @(negedge clk);
    chk({mem.rom_req, mem.ram_rd, mem.ram_wr, retire} == 4'b0, "reset_ctl",
        {mem.rom_req, mem.ram_rd, mem.ram_wr, retire}, 0);
    chk(pc_dbg == '0 && a_dbg == 16'h0 && d_dbg == 16'h0, "reset_regs", {pc_dbg, a_dbg}, 0);
    reset_n = 1'b1;

    // Directed program, zero-wait memories, cycle counts checked
    load_directed();
    ram[100] = 16'd10; mram[100] = 16'd10;
    ram[20]  = 16'd9;  mram[20]  = 16'd9;
    check_cycles = 1'b1;
    run_model(18);
    run_prog(18);
    chk(ram[100] == 16'd15, "ram100", ram[100], 16'd15);
    chk(ram[20] == 16'd8, "ram20", ram[20], 16'd8);
    idle_check();

    // Random program with random wait states
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < MEMSZ; i++) rom[i] = 16'($urandom);
    check_cycles = 1'b0;
    rom_wait_max = 3; ram_wait_max = 3;
    run_model(300);
    run_prog(300);
    idle_check();

    // Reset while a fetch is waiting for ack
    rom_wait_min = 20; rom_wait_max = 20;
    repeat (2) @(negedge clk);
    run = 1'b1;
    k = 0;
    while (!mem.rom_req && k < 5) begin @(negedge clk); k++; end
    chk(mem.rom_req, "midfetch_req_seen", mem.rom_req, 1);
    run = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk(!mem.rom_req, "midfetch_req_drop", mem.rom_req, 0);
    chk(pc_dbg == '0 && a_dbg == 16'h0 && d_dbg == 16'h0, "midfetch_regs", {pc_dbg, a_dbg}, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rom_wait_min = 0; rom_wait_max = 0; ram_wait_max = 0;
    load_directed();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Restart from RESET_PC
    check_cycles = 1'b1;
    run_model(5);
    run = 1'b1;
    k = 0;
    while (!mem.rom_req && k < 5) begin @(negedge clk); k++; end
    chk(mem.rom_req && mem.rom_addr == '0, "restart_addr", {mem.rom_req, mem.rom_addr}, 32'h8000);
    run_prog(5);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
Multi-cycle Hack CPU sequencer. It sits directly around the combinational ALU: it drives the ALU operands and the six control bits, and consumes the ALU result and flags. It owns the A, D and PC registers, fetches instructions from ROM and reads/writes data RAM over req/ack handshakes, so the ROM and RAM may be BRAM or SDRAM with arbitrary wait states.

Parameters:
ADDR_W, 15, width of the ROM and RAM address buses and of PC.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = start new instructions; 0 = hold in FETCH
rom_req  out  1  instruction read request
rom_addr  out  ADDR_W  instruction address (= PC)
rom_ack  in  1  instruction data valid this cycle
rom_data  in  16  instruction word
ram_rd  out  1  data read request
ram_wr  out  1  data write request
ram_addr  out  ADDR_W  data address (= A[ADDR_W-1:0])
ram_wdata  out  16  write data
ram_rdata  in  16  read data
ram_ack  in  1  read data valid / write accepted this cycle
alu_x  out  16  ALU x operand (= D)
alu_y  out  16  ALU y operand (= a-bit ? M latch : A)
alu_ctl  out  6  {zx,nx,zy,ny,f,no} = IR[11:6]
alu_out  in  16  ALU result
alu_zr  in  1  ALU zero flag
alu_ng  in  1  ALU negative flag
pc_dbg  out  ADDR_W  current PC
a_dbg  out  16  A register
d_dbg  out  16  D register
retire  out  1  one-cycle pulse when an instruction commits

Behaviour:
- Reset (async, reset_n=0): PC=RESET_PC; A, D, IR, M latch, R latch = 0; state FETCH; rom_req, ram_rd, ram_wr, retire = 0. All take effect immediately, including mid-handshake; any pending transfer is abandoned.
- States: FETCH, DECODE, MREAD, EXEC, MWRITE, COMMIT.
- FETCH: if run=1, rom_req=1, rom_addr=PC; both held stable until rom_ack is sampled high; ack may arrive in the first req cycle. On ack: IR<=rom_data, go to DECODE, rom_req drops next cycle. If run=0, no req; stay.
- DECODE: IR[15]=0 (A-instr): A<=zero-extended IR[14:0], PC<=PC+1, retire=1, go to FETCH. IR[15]=1 (C-instr): if IR[12]=1 go to MREAD, else EXEC.
- MREAD: ram_rd=1, ram_addr=A; held until ram_ack; on ack M<=ram_rdata, go to EXEC.
- EXEC: alu_x, alu_y and alu_ctl are valid from registers. The ALU is combinational, so R<=alu_out and flags are latched this cycle. Next state is MWRITE if IR[3] (dest M), else COMMIT.
- MWRITE: ram_wr=1, ram_addr=A (pre-instruction A), ram_wdata=R; held until ram_ack, then COMMIT.
- COMMIT: D<=R if IR[4]; A<=R if IR[5]. Jump if (IR[2]&ng)|(IR[1]&zr)|(IR[0]&~ng&~zr). PC<=jump ? old A[ADDR_W-1:0] : PC+1. retire=1; go to FETCH.
- Outside their states, alu operands stay driven; ram_addr=A and rom_addr=PC are always driven.
- Simultaneous dest-A plus jump or dest-M: the jump target and the RAM address both use A as it was before the instruction.
- PC increments modulo 2^ADDR_W (0x7FFF+1 -> 0).
- run is sampled only in FETCH with no request outstanding. Deasserting run mid-instruction completes that instruction. Once rom_req is raised it stays up until ack regardless of run.
- Minimum cycles per instruction with zero-wait acks: A-instr 2; C-instr 4; +1 for an M read; +1 for an M write.
- Never assert rom_req, ram_rd and ram_wr in the same cycle; at most one is ever high.

Decomposition:
- Shared package hack_pkg: state enum; IR field positions (IS_C=15, A_BIT=12, COMP=11:6, DEST_A=5, DEST_D=4, DEST_M=3, JMP=2:0); ADDR_W default.
- One sub-module: hack_jump_cond (combinational: jjj, zr, ng -> take).

Test Plan:
- Reset mid-fetch: pulse reset_n low while rom_req=1 awaiting ack -> rom_req=0 immediately, PC=0, A=D=0; after release, first rom_addr=0.
- A-instr: ROM[0]=0x1234, zero-wait -> A=0x1234, PC=1, retire after exactly 2 cycles.
- D=A: @7 then 0xEC10 -> alu_ctl=6'b110000 in EXEC, alu_y=7, D=7, no RAM access, 4 cycles.
- M=D+M with waits: A=100, D=5, RAM[100]=10, ram_ack delayed 3 cycles each -> ram_rd then ram_wr at addr 100 held stable, wdata=15, D unchanged.
- Jumps: A=40, 0xE301 (D;JGT) with D=-1 -> PC+1; with D=3 -> PC=40; 0xEA87 (0;JMP) -> PC=40.
- AM=M-1;JMP 0xFCAF with A=20, RAM[20]=9 -> RAM[20]=8, A=8, PC=20 (old A). PC=0x7FFF A-instr -> PC=0. run=0 -> no rom_req.
